// File: rtl/fifo_rd_stream_pkg.sv
// Shared types and helpers for the FIFO read-side stream adapter.
package fifo_rd_stream_pkg;

  localparam int unsigned BUF_DEPTH = 2;

  typedef logic [1:0] occ_t;
  typedef logic [2:0] cnt3_t;

  // Entries committed to the buffer after this cycle: buffered + in flight - leaving now.
  function automatic cnt3_t committed(input occ_t occ, input logic inflight, input logic pop);
    return cnt3_t'(occ) + cnt3_t'(inflight) - cnt3_t'(pop);
  endfunction

endpackage

// File: rtl/fifo_rd_stream_if.sv
// FIFO read port plus the downstream valid/ready stream, bundled for the adapter.
interface fifo_rd_stream_if #(parameter int WIDTH = 32);
  logic             i_fifo_empty;
  logic             o_fifo_r_e;
  logic [WIDTH-1:0] i_fifo_r_data;
  logic             i_fifo_r_ack;
  logic             o_valid;
  logic [WIDTH-1:0] o_data;
  logic             i_ready;

  modport master (
    input  i_fifo_empty, i_fifo_r_data, i_fifo_r_ack, i_ready,
    output o_fifo_r_e, o_valid, o_data
  );

  modport slave (
    output i_fifo_empty, i_fifo_r_data, i_fifo_r_ack, i_ready,
    input  o_fifo_r_e, o_valid, o_data
  );
endinterface

// File: rtl/fifo_rd_stream_buf2.sv
// Two-entry register buffer with push/pop/flush; absorbs one cycle of SRAM read latency.
module stream_buf2
  import fifo_rd_stream_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output occ_t             o_occ
);

  logic [WIDTH-1:0] mem_q [BUF_DEPTH];
  logic [WIDTH-1:0] mem_d [BUF_DEPTH];
  logic             head_q, head_d;
  logic             tail_q, tail_d;
  occ_t             occ_q, occ_d;

  always_comb begin
    mem_d  = mem_q;
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    if (i_flush) begin
      head_d = 1'b0;
      tail_d = 1'b0;
      occ_d  = '0;
    end else begin
      if (i_push) begin
        mem_d[tail_q] = i_push_data;
        tail_d        = ~tail_q;
      end
      if (i_pop) head_d = ~head_q;
      occ_d = occ_q + occ_t'(i_push) - occ_t'(i_pop);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      head_q <= 1'b0;
      tail_q <= 1'b0;
      occ_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
    end
  end

  // Payload storage carries no reset; occupancy alone qualifies it.
  always_ff @(posedge i_clk) begin
    mem_q <= mem_d;
  end

  assign o_valid = (occ_q != '0);
  assign o_data  = mem_q[head_q];
  assign o_occ   = occ_q;

endmodule

// File: rtl/fifo_rd_stream.sv
// Issues SRAM FIFO reads for a consumer and presents the returned data as a registered stream.
module fifo_rd_stream
  import fifo_rd_stream_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_flush,
  fifo_rd_stream_if.master      bus,
  output logic                  o_err
);

  logic inflight_q, inflight_d;
  logic err_q, err_d;
  logic pop, rd_en, overflow, capture;
  occ_t occ;

  assign pop = bus.o_valid & bus.i_ready;

  // Read-issue looks at this cycle's pop so two entries are enough for full throughput.
  assign rd_en = ~bus.i_fifo_empty & ~i_flush &
                 (committed(occ, inflight_q, pop) < cnt3_t'(BUF_DEPTH));

  always_comb begin
    overflow   = bus.i_fifo_r_ack & (occ == occ_t'(BUF_DEPTH)) & ~pop;
    capture    = bus.i_fifo_r_ack & ~i_flush & ~overflow;
    inflight_d = rd_en;
    err_d      = err_q | (bus.i_fifo_r_ack & ~i_flush & (~inflight_q | overflow));
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      inflight_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      inflight_q <= inflight_d;
      err_q      <= err_d;
    end
  end

  stream_buf2 #(.WIDTH(WIDTH)) u_buf (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_flush     (i_flush),
    .i_push      (capture),
    .i_push_data (bus.i_fifo_r_data),
    .i_pop       (pop),
    .o_valid     (bus.o_valid),
    .o_data      (bus.o_data),
    .o_occ       (occ)
  );

  assign bus.o_fifo_r_e = rd_en;
  assign o_err          = err_q;

endmodule
